// File: rtl/button_debouncer_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and counter sizing.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } db_state_e;

    // Counter must hold values 0..stable inclusive.
    function automatic int unsigned cnt_width(input int unsigned stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_sync2.sv
// Generic two-flop synchronizer for asynchronous board pins.
module button_debouncer_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button into a clean level plus one-cycle rise/fall pulses.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 50000,
    parameter bit          ACTIVE_LOW_BTN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic btn_rise_o,
    output logic btn_fall_o,
    output logic bouncing_o
);

    localparam int unsigned      CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             btn_norm;
    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             bouncing_q, bouncing_d;

    // Normalise so that 1 always means pressed.
    assign btn_norm = btn_raw_i ^ ACTIVE_LOW_BTN;

    button_debouncer_sync2 #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (btn_norm),
        .q_o    (s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE_LOW;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            bouncing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            bouncing_q <= bouncing_d;
        end
    end

    // Commit happens only when the counter has reached STABLE_CYCLES, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = PEND_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = PEND_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_LOW: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
        bouncing_d = (state_d == PEND_HIGH) || (state_d == PEND_LOW);
    end

    assign btn_level_o = level_q;
    assign btn_rise_o  = rise_q;
    assign btn_fall_o  = fall_q;
    assign bouncing_o  = bouncing_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4 and an active-low key.
module tb_button_debouncer;

    localparam int unsigned STABLE = 4;

    typedef struct {
        logic       raw;
        logic [3:0] expd;   // {level, rise, fall, bouncing}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic raw;
    logic level, rise, fall, bouncing;
    int   tests = 0;
    int   fails = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES  (STABLE),
        .ACTIVE_LOW_BTN (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_raw_i   (raw),
        .btn_level_o (level),
        .btn_rise_o  (rise),
        .btn_fall_o  (fall),
        .bouncing_o  (bouncing)
    );

    function automatic int outs();
        return int'({level, rise, fall, bouncing});
    endfunction

    task automatic check(input string name, input int act, input int expd);
        tests++;
        if (act !== expd) begin
            fails++;
            $display("FAIL %s: got %0d (0b%04b) expected %0d (0b%04b)", name, act, act[3:0], expd, expd[3:0]);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] e, input int n);
        for (int i = 0; i < n; i++) vq.push_back('{raw: r, expd: e});
    endtask

    initial begin
        int rise_at;
        int n_rise;
        int n_fall;

        // Clean press, held, then release
        add(1'b0, 4'b0000, 2);
        add(1'b0, 4'b0001, 4);
        add(1'b0, 4'b1100, 1);
        add(1'b0, 4'b1000, 2);
        add(1'b1, 4'b1000, 2);
        add(1'b1, 4'b1001, 4);
        add(1'b1, 4'b0010, 1);
        add(1'b1, 4'b0000, 2);
        // Three-cycle glitch is rejected
        add(1'b0, 4'b0000, 2);
        add(1'b0, 4'b0001, 1);
        add(1'b1, 4'b0001, 2);
        add(1'b1, 4'b0000, 3);
        // Bouncy press: toggles every cycle, then steady pressed
        add(1'b0, 4'b0000, 1);
        add(1'b1, 4'b0000, 1);
        add(1'b0, 4'b0001, 1);
        add(1'b1, 4'b0000, 1);
        add(1'b0, 4'b0001, 1);
        add(1'b1, 4'b0000, 1);
        add(1'b0, 4'b0001, 1);
        add(1'b0, 4'b0000, 1);
        add(1'b0, 4'b0001, 4);
        add(1'b0, 4'b1100, 1);
        add(1'b0, 4'b1000, 1);

        // Asynchronous reset with the button pressed, before any clock edge
        rst_n = 1'b1;
        raw   = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_async", outs(), 0);
        repeat (3) @(posedge clk);
        #1 check("reset_hold", outs(), 0);

        raw = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            raw = vq[i].raw;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), outs(), int'(vq[i].expd));
        end

        // Reset while HIGH: level drops, no fall pulse
        rst_n = 1'b0;
        #1 check("reset_mid_high", outs(), 0);
        @(posedge clk);
        #1 check("reset_mid_high_hold", outs(), 0);

        // Held through release; reset again in PEND_HIGH with cnt=2
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("pend_cnt2", outs(), 4'b0001);
        rst_n = 1'b0;
        #1 check("reset_mid_pend", outs(), 0);
        repeat (2) @(posedge clk);
        #1 check("reset_mid_pend_hold", outs(), 0);

        // Still held after release: rise on the 7th edge
        @(negedge clk);
        rst_n   = 1'b1;
        rise_at = -1;
        n_rise  = 0;
        n_fall  = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (rise) begin
                n_rise++;
                if (rise_at < 0) rise_at = e;
            end
            if (fall) n_fall++;
        end
        check("held_reset_rise_edge", rise_at, 6);
        check("held_reset_rise_count", n_rise, 1);
        check("held_reset_no_fall", n_fall, 0);
        check("held_reset_level", outs(), 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
